// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: bitwise two-input logic unit with one registered result
// stage behind a valid/ready handshake. An accumulator holds the most recent
// result so a beat can use it in place of operand A (chaining). Zero, all-ones
// and parity flags are registered together with the result.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_IMPL = 3'b111
  } op_e;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic [WIDTH-1:0] operand_x;
  logic [WIDTH-1:0] func_val;
  op_e              op_sel;

  // Selects operand X and evaluates the requested bitwise function.
  always_comb begin
    op_sel    = op_e'(in_op);
    operand_x = in_chain ? acc_q : in_a;
    func_val  = '0;
    case (op_sel)
      OP_AND:  func_val = operand_x & in_b;
      OP_OR:   func_val = operand_x | in_b;
      OP_NAND: func_val = ~(operand_x & in_b);
      OP_NOR:  func_val = ~(operand_x | in_b);
      OP_XOR:  func_val = operand_x ^ in_b;
      OP_XNOR: func_val = ~(operand_x ^ in_b);
      OP_ANDN: func_val = operand_x & ~in_b;
      OP_IMPL: func_val = ~operand_x | in_b;
      default: func_val = '0;
    endcase
  end

  // Handshake: a new beat fits when the result register is empty or being drained.
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
  end

  // Next-state for result, flags, accumulator and valid; everything holds unless a beat is accepted.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    parity_d    = parity_q;
    acc_d       = acc_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = func_val;
      zero_d      = (func_val == '0);
      ones_d      = (func_val == '1);
      parity_d    = ^func_val;
      acc_d       = func_val;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Result stage and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ones_q      <= 1'b0;
      parity_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      parity_q    <= parity_d;
      acc_q       <= acc_d;
    end
  end

  // Outputs come straight from the registers.
  always_comb begin
    out_valid  = out_valid_q;
    out_result = result_q;
    out_zero   = zero_q;
    out_ones   = ones_q;
    out_parity = parity_q;
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: three elaborations (WIDTH 8, 1, 32) share one
// stimulus stream; a truth-table model predicts every output each cycle, and
// directed beats pin the model with hand-computed values.
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        in_chain;
  logic        out_ready;

  logic        w8_in_ready, w8_out_valid, w8_zero, w8_ones, w8_parity;
  logic [7:0]  w8_result;
  logic        w1_in_ready, w1_out_valid, w1_zero, w1_ones, w1_parity;
  logic [0:0]  w1_result;
  logic        w32_in_ready, w32_out_valid, w32_zero, w32_ones, w32_parity;
  logic [31:0] w32_result;

  int total_checks;
  int bad_checks;
  int model_accepts;
  int dut_accepts;
  bit chk_en;

  logic        m_valid [3];
  logic [31:0] m_res   [3];
  logic [31:0] m_acc   [3];
  logic [31:0] m_mask  [3];

  logic [31:0] r1, r2, ra, rb;
  int          acc_before;

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(w8_in_ready),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_op(in_op), .in_chain(in_chain),
    .out_valid(w8_out_valid), .out_ready(out_ready), .out_result(w8_result),
    .out_zero(w8_zero), .out_ones(w8_ones), .out_parity(w8_parity)
  );

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(w1_in_ready),
    .in_a(in_a[0:0]), .in_b(in_b[0:0]), .in_op(in_op), .in_chain(in_chain),
    .out_valid(w1_out_valid), .out_ready(out_ready), .out_result(w1_result),
    .out_zero(w1_zero), .out_ones(w1_ones), .out_parity(w1_parity)
  );

  logic_unit_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(w32_in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
    .out_valid(w32_out_valid), .out_ready(out_ready), .out_result(w32_result),
    .out_zero(w32_zero), .out_ones(w32_ones), .out_parity(w32_parity)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Each op is a 4-entry truth table indexed by {x_bit, b_bit}; applied bit by bit.
  function automatic logic [31:0] opEval(input logic [2:0] op, input logic [31:0] x,
                                         input logic [31:0] b, input logic [31:0] mask);
    logic [3:0]  tt;
    logic [31:0] r;
    case (op)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0111;
      3'd3: tt = 4'b0001;
      3'd4: tt = 4'b0110;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0100;
      default: tt = 4'b1011;
    endcase
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) r[i] = tt[{x[i], b[i]}];
    end
    return r;
  endfunction

  // Behavioural model: result register and accumulator for each width, updated on each edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_valid[k] = 1'b0;
        m_res[k]   = '0;
        m_acc[k]   = '0;
      end else if (in_valid && (!m_valid[k] || out_ready)) begin
        m_res[k]   = opEval(in_op, in_chain ? m_acc[k] : (in_a & m_mask[k]), in_b & m_mask[k], m_mask[k]);
        m_acc[k]   = m_res[k];
        m_valid[k] = 1'b1;
        if (k == 0) model_accepts++;
      end else if (out_ready) begin
        m_valid[k] = 1'b0;
      end
    end
    if (rst) chk_en = 1'b1;
  end

  // Compare process: every output of every elaboration against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst && in_valid && w8_in_ready) dut_accepts++;
      checkOutput("w8_valid",   32'(w8_out_valid), 32'(m_valid[0]));
      checkOutput("w8_ready",   32'(w8_in_ready),  32'(!m_valid[0] || out_ready));
      checkOutput("w8_result",  32'(w8_result),    m_res[0]);
      checkOutput("w8_zero",    32'(w8_zero),      32'(m_res[0] == 32'h0));
      checkOutput("w8_ones",    32'(w8_ones),      32'(m_res[0] == m_mask[0]));
      checkOutput("w8_parity",  32'(w8_parity),    32'(^m_res[0]));
      checkOutput("w1_valid",   32'(w1_out_valid), 32'(m_valid[1]));
      checkOutput("w1_ready",   32'(w1_in_ready),  32'(!m_valid[1] || out_ready));
      checkOutput("w1_result",  32'(w1_result),    m_res[1]);
      checkOutput("w1_zero",    32'(w1_zero),      32'(m_res[1] == 32'h0));
      checkOutput("w1_ones",    32'(w1_ones),      32'(m_res[1] == m_mask[1]));
      checkOutput("w1_parity",  32'(w1_parity),    32'(^m_res[1]));
      checkOutput("w32_valid",  32'(w32_out_valid), 32'(m_valid[2]));
      checkOutput("w32_ready",  32'(w32_in_ready),  32'(!m_valid[2] || out_ready));
      checkOutput("w32_result", w32_result,         m_res[2]);
      checkOutput("w32_zero",   32'(w32_zero),      32'(m_res[2] == 32'h0));
      checkOutput("w32_ones",   32'(w32_ones),      32'(m_res[2] == m_mask[2]));
      checkOutput("w32_parity", 32'(w32_parity),    32'(^m_res[2]));
    end
  end

  // Drives one cycle of inputs just after a rising edge, then waits past the next edge.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic ch, input logic rdy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    in_chain  = ch;
    out_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  // Hard stop in case something stalls the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed and random stimulus with literal expectations.
  initial begin
    logic [7:0] sweep_exp [8];
    sweep_exp[0] = 8'h30; sweep_exp[1] = 8'hFC; sweep_exp[2] = 8'hCF; sweep_exp[3] = 8'h03;
    sweep_exp[4] = 8'hCC; sweep_exp[5] = 8'h33; sweep_exp[6] = 8'hC0; sweep_exp[7] = 8'h3F;
    m_mask[0] = 32'h0000_00FF;
    m_mask[1] = 32'h0000_0001;
    m_mask[2] = 32'hFFFF_FFFF;
    total_checks = 0; bad_checks = 0; model_accepts = 0; dut_accepts = 0; chk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0; m_res[k] = '0; m_acc[k] = '0;
    end
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_chain = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    // Reset state literals.
    checkOutput("rst_valid",  32'(w8_out_valid), 32'h0);
    checkOutput("rst_result", 32'(w8_result),    32'h00);
    checkOutput("rst_zero",   32'(w8_zero),      32'h1);
    checkOutput("rst_ones",   32'(w8_ones),      32'h0);
    checkOutput("rst_parity", 32'(w8_parity),    32'h0);
    checkOutput("rst_ready",  32'(w8_in_ready),  32'h1);

    // Op sweep F0 op 3C, back to back.
    for (int op = 0; op < 8; op++) begin
      applyStimulus(1'b1, 32'hF0, 32'h3C, 3'(op), 1'b0, 1'b1);
      checkOutput($sformatf("sweep_res_%0d", op), 32'(w8_result), 32'(sweep_exp[op]));
      checkOutput($sformatf("sweep_par_%0d", op), 32'(w8_parity), 32'h0);
      checkOutput($sformatf("sweep_zero_%0d", op), 32'(w8_zero), 32'h0);
      checkOutput($sformatf("sweep_ones_%0d", op), 32'(w8_ones), 32'h0);
    end

    // Chaining; operand A is a decoy on chained beats.
    applyStimulus(1'b1, 32'hF0, 32'h3C, 3'd0, 1'b0, 1'b1);
    checkOutput("chain_and", 32'(w8_result), 32'h30);
    applyStimulus(1'b1, 32'hAA, 32'h01, 3'd1, 1'b1, 1'b1);
    checkOutput("chain_or", 32'(w8_result), 32'h31);
    applyStimulus(1'b1, 32'h55, 32'h31, 3'd4, 1'b1, 1'b1);
    checkOutput("chain_xor", 32'(w8_result), 32'h00);
    checkOutput("chain_xor_zero", 32'(w8_zero), 32'h1);
    applyStimulus(1'b1, 32'h00, 32'h00, 3'd3, 1'b0, 1'b1);
    checkOutput("nor_ff", 32'(w8_result), 32'hFF);
    checkOutput("nor_ff_ones", 32'(w8_ones), 32'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);

    // Backpressure: hold A5 for five cycles while a beat waits.
    applyStimulus(1'b1, 32'hA5, 32'hFF, 3'd0, 1'b0, 1'b1);
    checkOutput("bp_first", 32'(w8_result), 32'hA5);
    acc_before = model_accepts;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h12, 32'h34, 3'd1, 1'b0, 1'b0);
      checkOutput("bp_hold_res",   32'(w8_result),    32'hA5);
      checkOutput("bp_hold_ready", 32'(w8_in_ready),  32'h0);
      checkOutput("bp_hold_valid", 32'(w8_out_valid), 32'h1);
    end
    applyStimulus(1'b1, 32'h12, 32'h34, 3'd1, 1'b0, 1'b1);
    checkOutput("bp_release_res", 32'(w8_result), 32'h36);
    checkOutput("bp_accept_count", 32'(model_accepts - acc_before), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);
    checkOutput("bp_drained", 32'(w8_out_valid), 32'h0);

    // Reset mid-stream with a beat offered during reset.
    applyStimulus(1'b1, 32'h3C, 32'hFF, 3'd0, 1'b0, 1'b0);
    checkOutput("mid_pre", 32'(w8_result), 32'h3C);
    rst = 1'b1;
    applyStimulus(1'b1, 32'hFF, 32'hFF, 3'd1, 1'b0, 1'b1);
    rst = 1'b0;
    checkOutput("mid_valid",  32'(w8_out_valid), 32'h0);
    checkOutput("mid_result", 32'(w8_result),    32'h00);
    checkOutput("mid_zero",   32'(w8_zero),      32'h1);
    applyStimulus(1'b1, 32'h55, 32'h00, 3'd1, 1'b1, 1'b1);
    checkOutput("mid_acc_chain", 32'(w8_result), 32'h00);

    // De Morgan identities on random operands.
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      applyStimulus(1'b1, ra, rb, 3'd2, 1'b0, 1'b1);
      r1 = 32'(w8_result);
      applyStimulus(1'b1, ~ra, ~rb, 3'd1, 1'b0, 1'b1);
      r2 = 32'(w8_result);
      checkOutput("demorgan_nand", r2, r1);
      applyStimulus(1'b1, ra, rb, 3'd3, 1'b0, 1'b1);
      r1 = 32'(w8_result);
      applyStimulus(1'b1, ~ra, ~rb, 3'd0, 1'b0, 1'b1);
      r2 = 32'(w8_result);
      checkOutput("demorgan_nor", r2, r1);
    end

    // WIDTH=1 truth table sweep (model covers all three widths).
    for (int op = 0; op < 8; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        applyStimulus(1'b1, 32'(ab >> 1), 32'(ab & 1), 3'(op), 1'b0, 1'b1);
      end
    end
    applyStimulus(1'b1, 32'h1, 32'h0, 3'd7, 1'b0, 1'b1);
    checkOutput("w1_impl_10",      32'(w1_result), 32'h0);
    checkOutput("w1_impl_10_zero", 32'(w1_zero),   32'h1);

    // WIDTH=32 flag literals.
    applyStimulus(1'b1, 32'h0000_0001, 32'h0, 3'd1, 1'b0, 1'b1);
    checkOutput("w32_par_one", 32'(w32_parity), 32'h1);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0, 3'd1, 1'b0, 1'b1);
    checkOutput("w32_ones_lit", 32'(w32_ones),   32'h1);
    checkOutput("w32_par_ff",   32'(w32_parity), 32'h0);

    // Random traffic with random backpressure and chaining.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);

    @(negedge clk);
    checkOutput("accept_count", 32'(dut_accepts), 32'(model_accepts));
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
